scr_trigger_pulse_gen: RTL and testbench
========================================

// Module: scr_trigger_pulse_gen
// PURPOSE
//  Generates the alternating forward/negative SCR trigger pulses and the pulse-forbid level for the LE-board
//  breakdown/BOD test. Its outputs drive the detector's forward, negative and forbid inputs.
//  Runs a burst of N full cycles, or runs continuously, on a 50 MHz clock.
//  One cycle is: forward pulse, half period, negative pulse, half period.
// PARAMETERS
//  HALF_PERIOD  20'd500000  clocks from one pulse's rising edge to the next opposite pulse (10 ms @ 50 MHz)
//  PULSE_WIDTH  20'd5000    trigger pulse high time in clocks (100 us); 1 <= PULSE_WIDTH < HALF_PERIOD
//  ARM_TIME     20'd50000   clocks with forbid low and no pulse before the first forward pulse (1 ms); >= 1
// PORTS
//  i_clk_50m          in   1   50 MHz clock
//  i_rst_n            in   1   asynchronous active-low reset
//  i_start            in   1   1-clk start strobe, synchronous
//  i_stop             in   1   1-clk abort strobe, synchronous
//  i_burst_num        in   8   number of full cycles to run; 0 = continuous until i_stop
//  o_signal_forward   out  1   forward trigger pulse, 1 = fire
//  o_signal_negative  out  1   negative trigger pulse, 1 = fire
//  o_signal_forbid    out  1   pulse forbid, 1 = forbidden (detector held off)
//  o_busy             out  1   1 in every state except IDLE
//  o_done             out  1   1-clk strobe when a burst completes normally
//  o_cycle_cnt        out  8   completed full cycles in the current or last burst
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, o_signal_forbid=1, every other output=0, counters=0.
//  - All outputs are registered and decoded from the next state. They change on the clock edge that samples the cause.
//  - FSM: IDLE -> ARM -> FWD_PULSE -> FWD_GAP -> NEG_PULSE -> NEG_GAP -> (FWD_PULSE | IDLE).
//  - One 20-bit down-counter, tmr, is loaded on every state entry:
//      ARM=ARM_TIME, *_PULSE=PULSE_WIDTH, *_GAP=HALF_PERIOD-PULSE_WIDTH.
//    The state exits on the edge where tmr==1, so each state lasts exactly its load value in clocks.
//  - IDLE: forbid=1, pulses=0, busy=0.
//    On i_start (with i_stop=0): latch i_burst_num, clear o_cycle_cnt, go to ARM.
//    On the next edge forbid=0 and busy=1.
//  - ARM: forbid=0, pulses=0.
//  - FWD_PULSE: o_signal_forward=1. NEG_PULSE: o_signal_negative=1.
//    The two pulses are never high together; forbid stays 0.
//  - NEG_GAP exit: o_cycle_cnt+1 (8-bit, wraps 255->0 in continuous mode).
//    If the latched burst is nonzero and the new count equals it: go to IDLE, o_done=1 for one clock, forbid=1.
//    Otherwise go to FWD_PULSE.
//  - Forward-edge to negative-edge spacing = HALF_PERIOD clocks.
//    Negative-edge to next forward-edge spacing = HALF_PERIOD clocks.
//  - i_stop in any non-IDLE state: next edge state=IDLE, pulses=0, forbid=1, busy=0, o_done=0.
//    An in-flight pulse is truncated. o_cycle_cnt holds its value.
//  - i_start while busy: ignored. i_start and i_stop in the same clock: stop wins (from IDLE: stays IDLE).
//  - i_stop in IDLE: no effect. i_burst_num changes while busy: ignored (latched at start).
//  - o_done and start in the same clock: not possible; the start is seen earliest on the clock after IDLE is re-entered.
// TESTING  (sim params HALF_PERIOD=20, PULSE_WIDTH=4, ARM_TIME=3)
//  1 Reset:
//    i_rst_n low mid-FWD_PULSE -> outputs immediately forbid=1, fwd=0, neg=0, busy=0, cnt=0.
//  2 Burst of 2:
//    i_start at clk 0 -> forbid=0 at clk 1; fwd high clks 4-7; neg high clks 24-27; fwd high clks 44-47;
//    neg high clks 64-67; o_done=1 and forbid=1 at clk 84; cnt=2.
//  3 Continuous (burst=0):
//    run 300 cycles -> cnt wraps to 44; pulses never overlap; edge spacing always 20.
//  4 Abort:
//    i_stop at the 2nd clk of NEG_PULSE -> neg=0 and forbid=1 next clk; no o_done; cnt held at 0.
//  5 Collisions:
//    i_start+i_stop together in IDLE -> stays IDLE;
//    i_start during FWD_GAP -> timing unchanged vs scenario 2.
//  6 Burst=1 with i_burst_num changed to 3 after start -> exactly 1 cycle, o_done at clk 44.

Source files
------------

// File: rtl/scr_trigger_pulse_gen.sv
// SCR trigger pulse generator: alternating forward/negative trigger pulses with a
// pulse-forbid level, for a burst of N full cycles or continuously until stopped.
module scr_trigger_pulse_gen #(
  parameter logic [19:0] HALF_PERIOD = 20'd500000,
  parameter logic [19:0] PULSE_WIDTH = 20'd5000,
  parameter logic [19:0] ARM_TIME    = 20'd50000
) (
  input  logic       i_clk_50m,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic [7:0] i_burst_num,
  output logic       o_signal_forward,
  output logic       o_signal_negative,
  output logic       o_signal_forbid,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FWD_PULSE,
    S_FWD_GAP,
    S_NEG_PULSE,
    S_NEG_GAP
  } state_e;

  localparam logic [19:0] GAP_TIME = HALF_PERIOD - PULSE_WIDTH;

  state_e      state_q, state_d;
  logic [19:0] tmr_q, tmr_d;
  logic [7:0]  burst_q, burst_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_d;
  logic        fwd_q, neg_q, forbid_q, busy_q, done_q;

  // NOTE: every signal gets a default at the top of the block, so no path
  // through the if/case tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (state_q == S_IDLE) begin
      if (i_start && !i_stop) begin
        state_d = S_ARM;
        tmr_d   = ARM_TIME;
        burst_d = i_burst_num;
        cnt_d   = 8'd0;
      end
    end else if (i_stop) begin
      // Abort truncates any pulse in flight; the cycle count is kept.
      state_d = S_IDLE;
      tmr_d   = 20'd0;
    end else if (tmr_q == 20'd1) begin
      case (state_q)
        S_ARM: begin
          state_d = S_FWD_PULSE;
          tmr_d   = PULSE_WIDTH;
        end
        S_FWD_PULSE: begin
          state_d = S_FWD_GAP;
          tmr_d   = GAP_TIME;
        end
        S_FWD_GAP: begin
          state_d = S_NEG_PULSE;
          tmr_d   = PULSE_WIDTH;
        end
        S_NEG_PULSE: begin
          state_d = S_NEG_GAP;
          tmr_d   = GAP_TIME;
        end
        S_NEG_GAP: begin
          cnt_d = cnt_q + 8'd1;
          if ((burst_q != 8'd0) && (cnt_d == burst_q)) begin
            state_d = S_IDLE;
            tmr_d   = 20'd0;
            done_d  = 1'b1;
          end else begin
            state_d = S_FWD_PULSE;
            tmr_d   = PULSE_WIDTH;
          end
        end
        default: begin
          state_d = S_IDLE;
          tmr_d   = 20'd0;
        end
      endcase
    end else begin
      tmr_d = tmr_q - 20'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      tmr_q    <= 20'd0;
      burst_q  <= 8'd0;
      cnt_q    <= 8'd0;
      fwd_q    <= 1'b0;
      neg_q    <= 1'b0;
      forbid_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      burst_q  <= burst_d;
      cnt_q    <= cnt_d;
      // Outputs decode the next state so they move on the same edge as the state.
      fwd_q    <= (state_d == S_FWD_PULSE);
      neg_q    <= (state_d == S_NEG_PULSE);
      forbid_q <= (state_d == S_IDLE);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= done_d;
    end
  end

  assign o_signal_forward  = fwd_q;
  assign o_signal_negative = neg_q;
  assign o_signal_forbid   = forbid_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_cycle_cnt       = cnt_q;

endmodule

// File: tb/tb_scr_trigger_pulse_gen.sv
// Directed bench for scr_trigger_pulse_gen with short timing parameters
// (half period 20, pulse 4, arm 3 clocks; one full cycle = 40 clocks).
module tb_scr_trigger_pulse_gen;

  localparam logic [19:0] HP = 20'd20;
  localparam logic [19:0] PW = 20'd4;
  localparam logic [19:0] AT = 20'd3;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic       stop   = 1'b0;
  logic [7:0] burst  = 8'd0;
  logic       fwd, neg, forbid, busy, done;
  logic [7:0] cnt;

  int n_checks = 0;
  int n_fail   = 0;

  scr_trigger_pulse_gen #(
    .HALF_PERIOD(HP),
    .PULSE_WIDTH(PW),
    .ARM_TIME   (AT)
  ) dut (
    .i_clk_50m        (clk),
    .i_rst_n          (rst_n),
    .i_start          (start),
    .i_stop           (stop),
    .i_burst_num      (burst),
    .o_signal_forward (fwd),
    .o_signal_negative(neg),
    .o_signal_forbid  (forbid),
    .o_busy           (busy),
    .o_done           (done),
    .o_cycle_cnt      (cnt)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [7:0] exp_cnt);
    check({tag, " fwd"},    32'(fwd),    32'd0);
    check({tag, " neg"},    32'(neg),    32'd0);
    check({tag, " forbid"}, 32'(forbid), 32'd1);
    check({tag, " busy"},   32'(busy),   32'd0);
    check({tag, " done"},   32'(done),   32'd0);
    check({tag, " cnt"},    32'(cnt),    32'(exp_cnt));
  endtask

  // Start a burst in the current cycle (cycle 0) and check every output each
  // cycle until one cycle past the expected o_done strobe.
  task automatic run_burst(input logic [7:0] n_start, input logic [7:0] n_late,
                           input int restart_at, input string tag);
    int   end_c;
    int   phase;
    logic active;
    end_c = 4 + 40 * int'(n_start);
    start = 1'b1;
    burst = n_start;
    for (int c = 1; c <= end_c + 1; c++) begin
      step();
      start = (c == restart_at);
      if (c == 1) burst = n_late;
      active = (c >= 4) && (c < end_c);
      phase  = (c >= 4) ? (c - 4) % 40 : 0;
      check($sformatf("%s fwd c%0d", tag, c), 32'(fwd), 32'(active && phase < 4));
      check($sformatf("%s neg c%0d", tag, c), 32'(neg),
            32'(active && phase >= 20 && phase < 24));
      check($sformatf("%s forbid c%0d", tag, c), 32'(forbid), 32'(c >= end_c));
      check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(c < end_c));
      check($sformatf("%s done c%0d", tag, c), 32'(done), 32'(c == end_c));
      check($sformatf("%s cnt c%0d", tag, c), 32'(cnt), 32'((c < 4) ? 0 : (c - 4) / 40));
    end
    start = 1'b0;
  endtask

  initial begin
    int overlap;
    int last_rise;
    int done_seen;
    logic prev_fwd, prev_neg;

    // Reset state
    #25;
    check_idle("reset", 8'd0);
    rst_n = 1'b1;
    step();
    check_idle("post_reset", 8'd0);

    // Asynchronous reset in the middle of the second forward pulse
    start = 1'b1;
    burst = 8'd2;
    for (int c = 1; c <= 45; c++) begin
      step();
      start = 1'b0;
    end
    check("pre_rst fwd", 32'(fwd), 32'd1);
    check("pre_rst cnt", 32'(cnt), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check_idle("async_rst", 8'd0);
    step();
    rst_n = 1'b1;
    step();
    check_idle("rst_release", 8'd0);

    // Burst of 2
    run_burst(8'd2, 8'd2, -1, "burst2");

    // Start and stop together in IDLE, then stop alone in IDLE
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check_idle("start_stop", 8'd2);
    step();
    check_idle("start_stop+1", 8'd2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_idle("stop_idle", 8'd2);

    // Start while busy (cycle 10 is inside FWD_GAP) must not disturb timing
    run_burst(8'd2, 8'd2, 10, "restart");

    // Burst of 1 with the burst number changed after the start
    run_burst(8'd1, 8'd3, -1, "burst1");

    // Abort on the second clock of the first negative pulse
    start = 1'b1;
    burst = 8'd2;
    for (int c = 1; c <= 25; c++) begin
      step();
      start = 1'b0;
    end
    check("abort pre neg", 32'(neg), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_idle("abort", 8'd0);
    done_seen = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (done || busy) done_seen++;
    end
    check("abort quiet", 32'(done_seen), 32'd0);

    // Continuous run of 300 cycles: count wraps to 44
    start     = 1'b1;
    burst     = 8'd0;
    overlap   = 0;
    last_rise = -1;
    prev_fwd  = 1'b0;
    prev_neg  = 1'b0;
    for (int c = 1; c <= 12004; c++) begin
      step();
      start = 1'b0;
      if (fwd && neg) overlap++;
      if ((fwd && !prev_fwd) || (neg && !prev_neg)) begin
        if (last_rise < 0) check("cont first rise", 32'(c), 32'd4);
        else check($sformatf("cont spacing c%0d", c), 32'(c - last_rise), 32'd20);
        last_rise = c;
      end
      prev_fwd = fwd;
      prev_neg = neg;
      if (c == 12003) check("cont cnt 43", 32'(cnt), 32'd43);
    end
    check("cont overlap", 32'(overlap), 32'd0);
    check("cont cnt", 32'(cnt), 32'd44);
    check("cont busy", 32'(busy), 32'd1);
    check("cont forbid", 32'(forbid), 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_idle("cont stop", 8'd44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
